// File: rtl/sync_debounce_edge.sv
// Per-channel synchronizer, debounce filter and rise/fall edge pulses for raw switch inputs.
// Define SYNC_DEBOUNCE_EDGE_REPEAT_EN to add auto-repeat strobes while a channel is held high.
module sync_debounce_edge #(
  parameter int W               = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int ACTIVE_LOW      = 0,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw_in,
  output logic [W-1:0] sw_out,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic [W-1:0] repeat_pulse
);

  localparam int           CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0]  INV_MASK = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  logic [W-1:0]  sync_q [SYNC_STAGES];
  logic [CW-1:0] cnt      [W];
  logic [CW-1:0] cnt_next [W];
  logic [W-1:0]  s;
  logic [W-1:0]  sw_next;
  logic [W-1:0]  rise_d;
  logic [W-1:0]  fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // A change is accepted only on the cycle the counter is at its last value, so
  // the counter never exceeds DEBOUNCE_CYCLES-1 and any glitch clears it.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    sw_next = sw_out;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < W; i++) begin
      cnt_next[i] = '0;
      if (s[i] != sw_out[i]) begin
        if (cnt[i] == CNT_LAST) begin
          sw_next[i] = s[i];
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these per-channel arrays are plain flops, not RAM, so they take the reset too.
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < W; i++) cnt[i] <= '0;
      sw_out <= '0;
      rise   <= '0;
      fall   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the shift chain a true chain of flops.
      sync_q[0] <= sw_in ^ INV_MASK;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < W; i++) cnt[i] <= cnt_next[i];
      sw_out <= sw_next;
      rise   <= rise_d;
      fall   <= fall_d;
    end
  end

`ifdef SYNC_DEBOUNCE_EDGE_REPEAT_EN
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  logic [HW-1:0] hcnt [W];
  logic [W-1:0]  rep_phase;
  logic [W-1:0]  rep_d;

  // hcnt restarts at 0 on the cycle after rise and after each strobe, so the hold
  // target is one less than the repeat target; a pending fall suppresses the strobe.
  always_comb begin
    rep_d = '0;
    for (int i = 0; i < W; i++) begin
      if (sw_out[i] && !fall_d[i]) begin
        if (rep_phase[i])          rep_d[i] = (int'(hcnt[i]) == REPEAT_CYCLES - 1);
        else if (HOLD_CYCLES == 1) rep_d[i] = rise[i];
        else                       rep_d[i] = !rise[i] && (int'(hcnt[i]) == HOLD_CYCLES - 2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < W; i++) hcnt[i] <= '0;
      rep_phase    <= '0;
      repeat_pulse <= '0;
    end else begin
      repeat_pulse <= rep_d;
      for (int i = 0; i < W; i++) begin
        if (rep_d[i]) begin
          hcnt[i]      <= '0;
          rep_phase[i] <= 1'b1;
        end else if (!sw_out[i] || rise[i]) begin
          hcnt[i]      <= '0;
          rep_phase[i] <= 1'b0;
        end else begin
          hcnt[i]      <= hcnt[i] + HW'(1);
        end
      end
    end
  end
`else
  assign repeat_pulse = '0;
`endif

endmodule
